// File: rtl/act_pkg.sv
// Shared constants for the piecewise-linear activation unit.
// Breakpoints and offsets are held in Q.16 and truncated to FRAC_W.
package act_pkg;

  typedef enum logic [1:0] {
    MODE_ID   = 2'b00,
    MODE_RELU = 2'b01,
    MODE_SIG  = 2'b10,
    MODE_TANH = 2'b11
  } act_mode_e;

  localparam int Q16_ONE    = 65536;
  localparam int Q16_BP_1   = 65536;
  localparam int Q16_BP_2P4 = 155648;
  localparam int Q16_BP_5   = 327680;
  localparam int Q16_OFF_05 = 32768;
  localparam int Q16_OFF_06 = 40960;
  localparam int Q16_OFF_08 = 55296;

  function automatic int act_scale(int q16, int frac_w);
    return q16 >>> (16 - frac_w);
  endfunction

endpackage

// File: rtl/act_pla_lane.sv
// One activation lane: abs/sign, segment shift-add, reflection and output.
// Tanh datapath present only with ACTIVATION_TANH_EN defined.
module act_pla_lane
  import act_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] f_x
);

  localparam logic [DATA_W-1:0] MAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ONE =
    DATA_W'(act_scale(Q16_ONE, FRAC_W));
  localparam logic [DATA_W-1:0] BP_1 =
    DATA_W'(act_scale(Q16_BP_1, FRAC_W));
  localparam logic [DATA_W-1:0] BP_2P4 =
    DATA_W'(act_scale(Q16_BP_2P4, FRAC_W));
  localparam logic [DATA_W-1:0] BP_5 =
    DATA_W'(act_scale(Q16_BP_5, FRAC_W));
  localparam logic [DATA_W-1:0] OFF_05 =
    DATA_W'(act_scale(Q16_OFF_05, FRAC_W));
  localparam logic [DATA_W-1:0] OFF_06 =
    DATA_W'(act_scale(Q16_OFF_06, FRAC_W));
  localparam logic [DATA_W-1:0] OFF_08 =
    DATA_W'(act_scale(Q16_OFF_08, FRAC_W));

  logic [DATA_W-1:0] xin, a;
  logic              neg;

  // tanh feeds 2x (saturated) into the sigmoid path
  always_comb begin
    xin = x;
`ifdef ACTIVATION_TANH_EN
    if (mode == MODE_TANH) begin
      if (x[DATA_W-1] != x[DATA_W-2])
        xin = x[DATA_W-1] ? MIN : MAX;
      else
        xin = {x[DATA_W-2:0], 1'b0};
    end
`endif
    neg = xin[DATA_W-1];
    if (!neg)
      a = xin;
    else if (xin == MIN)
      a = MAX;
    else
      a = -xin;
  end

  logic [DATA_W-1:0] s1_x, s1_a;
  logic [1:0]        s1_mode;
  logic              s1_neg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_x    <= '0;
      s1_a    <= '0;
      s1_mode <= '0;
      s1_neg  <= 1'b0;
    end else if (en) begin
      s1_x    <= x;
      s1_a    <= a;
      s1_mode <= mode;
      s1_neg  <= neg;
    end
  end

  logic [DATA_W-1:0] y;

  always_comb begin
    if (s1_a >= BP_5)
      y = ONE;
    else if (s1_a >= BP_2P4)
      y = (s1_a >> 5) + OFF_08;
    else if (s1_a >= BP_1)
      y = (s1_a >> 3) + OFF_06;
    else
      y = (s1_a >> 2) + OFF_05;
  end

  logic [DATA_W-1:0] s2_x, s2_y;
  logic [1:0]        s2_mode;
  logic              s2_neg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_x    <= '0;
      s2_y    <= '0;
      s2_mode <= '0;
      s2_neg  <= 1'b0;
    end else if (en) begin
      s2_x    <= s1_x;
      s2_y    <= y;
      s2_mode <= s1_mode;
      s2_neg  <= s1_neg;
    end
  end

  logic [DATA_W-1:0] sig, res;

  always_comb begin
    sig = s2_neg ? ONE - s2_y : s2_y;
    unique case (s2_mode)
      MODE_RELU: res = s2_x[DATA_W-1] ? '0 : s2_x;
      MODE_SIG:  res = sig;
`ifdef ACTIVATION_TANH_EN
      MODE_TANH: res = (sig << 1) - ONE;
`endif
      default:   res = s2_x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      f_x <= '0;
    else if (en)
      f_x <= res;
  end

endmodule

// File: rtl/activation_unit.sv
// LANES-wide 3-stage activation pipeline with valid/ready handshake.
// Optional tanh mode: define ACTIVATION_TANH_EN.
module activation_unit #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int LANES  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [1:0]              mode,
  input  logic [LANES*DATA_W-1:0] x,
  output logic [LANES*DATA_W-1:0] f_x,
  output logic                    valid_out,
  input  logic                    ready_out
);

  logic advance;
  logic v1, v2;

  assign advance  = ~valid_out | ready_out;
  assign ready_in = advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      valid_out <= 1'b0;
    end else if (advance) begin
      v1        <= valid_in;
      v2        <= v1;
      valid_out <= v2;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_pla_lane #(
      .DATA_W(DATA_W),
      .FRAC_W(FRAC_W)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .en   (advance),
      .mode (mode),
      .x    (x[i*DATA_W +: DATA_W]),
      .f_x  (f_x[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_activation_unit.sv
// Scoreboard bench for activation_unit (DATA_W=16, FRAC_W=8, LANES=4).
// Tanh vectors selected by ACTIVATION_TANH_EN.
module tb_activation_unit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic         ready_in;
  logic [1:0]   mode;
  logic [W-1:0] x;
  logic [W-1:0] f_x;
  logic         valid_out;
  logic         ready_out;

  activation_unit #(
    .DATA_W(16),
    .FRAC_W(8),
    .LANES (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .mode     (mode),
    .x        (x),
    .f_x      (f_x),
    .valid_out(valid_out),
    .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] exp;
    int           acc;
    bit           chk;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset && valid_out && ready_out) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out got=%h need=none", f_x);
      end else begin
        e = sb.pop_front();
        if (f_x !== e.exp) begin
          bad++;
          $display("FAIL result got=%h need=%h", f_x, e.exp);
        end
        if (e.chk) begin
          total++;
          if (cyc - e.acc != 3) begin
            bad++;
            $display("FAIL latency got=%0d need=3", cyc - e.acc);
          end
        end
      end
    end
  end

  task automatic chk(input string n, input logic [W-1:0] got,
                     input logic [W-1:0] need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s got=%h need=%h", n, got, need);
    end
  endtask

  task automatic send(input logic [1:0] m, input logic [W-1:0] xv,
                      input logic [W-1:0] ev, input bit lat);
    bit done = 1'b0;
    mode     = m;
    x        = xv;
    valid_in = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (ready_in) begin
        sb.push_back(exp_t'{ev, cyc, lat});
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=stuck need=accept");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++)
      @(posedge clk);
    #1;
    chk("drain", W'(sb.size()), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running need=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [W-1:0] held;
    reset     = 1'b1;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    mode      = 2'b00;
    x         = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_vout", W'(valid_out), W'(1'b0));
    chk("rst_fx", f_x, '0);
    chk("rst_rin", W'(ready_in), W'(1'b1));
    @(posedge clk);
    #1;

    send(2'b10, {16'h0800, 16'hFF00, 16'h0100, 16'h0000},
         {16'h0100, 16'h0040, 16'h00C0, 16'h0080}, 1'b1);
    send(2'b10, {16'h8000, 16'hFB00, 16'h0300, 16'h0260},
         {16'h0000, 16'h0000, 16'h00F0, 16'h00EB}, 1'b1);
    send(2'b10, {16'h04FF, 16'h025F, 16'h00FF, 16'h0080},
         {16'h00FF, 16'h00EB, 16'h00BF, 16'h00A0}, 1'b1);
    send(2'b01, {16'h7FFF, 16'h8000, 16'h0280, 16'hFD00},
         {16'h7FFF, 16'h0000, 16'h0280, 16'h0000}, 1'b1);
    send(2'b00, {16'h8000, 16'hFFFF, 16'h1234, 16'h8000},
         {16'h8000, 16'hFFFF, 16'h1234, 16'h8000}, 1'b1);
`ifdef ACTIVATION_TANH_EN
    send(2'b11, {16'hFF80, 16'h0000, 16'h7FFF, 16'h0080},
         {16'hFF80, 16'h0000, 16'h0100, 16'h0080}, 1'b1);
`else
    send(2'b11, {16'hFF80, 16'h0000, 16'h7FFF, 16'h0080},
         {16'hFF80, 16'h0000, 16'h7FFF, 16'h0080}, 1'b1);
`endif
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        send(2'b10, {4{16'h0200}}, {4{16'h00E0}}, 1'b1);
      else
        send(2'b01, {4{16'h0200}}, {4{16'h0200}}, 1'b1);
    end
    drain();

    ready_out = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++)
          send(2'b00, {4{16'(k * 16'h1111)}},
               {4{16'(k * 16'h1111)}}, 1'b0);
      end
      begin
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          seen = valid_out;
        end
        chk("stall_fill", W'(seen), W'(1'b1));
        held = f_x;
        for (int j = 0; j < 5; j++) begin
          if (j > 0) @(negedge clk);
          chk("stall_vout", W'(valid_out), W'(1'b1));
          chk("stall_hold", f_x, held);
          chk("stall_rin", W'(ready_in), W'(1'b0));
        end
        @(posedge clk);
        #1 ready_out = 1'b1;
      end
    join
    drain();

    send(2'b10, {4{16'h0100}}, {4{16'h00C0}}, 1'b0);
    send(2'b01, {4{16'h0100}}, {4{16'h0100}}, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_vout", W'(valid_out), W'(1'b0));
    end
    @(posedge clk);
    #1;
    send(2'b10, {4{16'hFF00}}, {4{16'h0040}}, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
